pc_reg: RTL and testbench
=========================

# pc_reg

Program-counter generation stage of the simplemips pipeline, directly upstream of the IF stage. It drives IF's fetch address and the instruction-ROM chip enable. Each cycle it picks the next fetch address from sequential increment, a branch/jump resolved in ID, or an exception/ERET redirect, and it honours pipeline stalls. It buffers a branch that resolves during a stall so the branch is never lost.

## Interface
Parameters:
- ADDR_W, 32: address width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold PC this cycle (from pipeline control).
- flush_i  in  1  redirect to new_pc_i (exception entry / ERET).
- new_pc_i  in  ADDR_W  redirect target, sampled only when flush_i=1.
- branch_flag_i  in  1  taken branch/jump resolved in ID this cycle.
- branch_target_i  in  ADDR_W  branch/jump target, valid with branch_flag_i.
- pc_o  out  ADDR_W  fetch address; feeds IF addr_i.
- ce_o  out  1  fetch enable; feeds IF / ROM enable.
- br_pend_o  out  1  a branch target is buffered awaiting release (debug/verification).

## Operation
- Two states: BOOT and RUN. Pending-branch register: pend (1 bit) plus pend_target (ADDR_W).
- Reset (async, rst_n=0): state=BOOT, pc_o=RESET_PC, ce_o=0, pend=0, pend_target=0, br_pend_o=0.
- BOOT: the first rising edge with rst_n=1 moves to RUN and sets ce_o=1. pc_o stays RESET_PC, so the first fetch is RESET_PC. All other inputs are ignored in BOOT.
- RUN: per-edge priority, highest first:
  1. flush_i=1: pc_o<=new_pc_i; pend<=0.
  2. stall_i=1: pc_o holds. If branch_flag_i=1, pend<=1 and pend_target<=branch_target_i; a newer capture overwrites an older one.
  3. branch_flag_i=1: pc_o<=branch_target_i; pend<=0.
  4. pend=1: pc_o<=pend_target; pend<=0.
  5. Otherwise: pc_o<=pc_o+4.
- Arithmetic: the increment is modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 gives 32'h0000_0000 with no flag. Low two bits pass through unchanged. Misaligned targets are not checked here; IF/exception logic owns alignment faults.
- Delay slot: the instruction fetched in the cycle the branch resolves is the delay slot and is not squashed by this block.
- ce_o stays 1 in RUN and is cleared only by reset.
- A reset asserted mid-operation drops pending branches immediately and restarts at BOOT.

## Timing
- pc_o, ce_o and br_pend_o are registered outputs with no combinational path from any input.
- Redirect latency is 1 cycle. A branch or flush sampled at edge t appears on pc_o after edge t.
- A branch resolved during a stall is released on the first non-stalled, non-flushed edge. There is no extra bubble beyond the stall itself.
- Simultaneous flush_i and branch_flag_i: flush wins and the branch is discarded.
- Simultaneous stall_i and flush_i: flush wins and pending is cleared.
- Simultaneous branch_flag_i and existing pend, unstalled: the new branch wins and pend clears.

## Structure
- Shared package mips_defs: ADDR_W, INST_BYTES=4, RESET_PC, state encoding (BOOT, RUN). The IF, ID and ctrl blocks reuse these.
- No sub-module. The block is one state register and a priority next-PC mux in a single module.

## Test plan
- Reset release: rst_n 0→1 → ce_o=0 and pc_o=0 for one edge, then ce_o=1 with pc_o sequence 0, 4, 8, 12.
- Branch: branch_flag_i=1 with target 0x0000_0100 while pc_o=0x8 → next pc_o=0x100, then 0x104.
- Stall-captured branch: stall_i=1 for 3 cycles with branch_flag_i pulsed in cycle 1 (target 0x200) → pc_o holds and br_pend_o=1 during the stall. The first free edge gives pc_o=0x200 and br_pend_o=0.
- Flush priority: flush_i=1 (new_pc_i=0x180), stall_i=1 and branch_flag_i=1 (target 0x300) together → pc_o=0x180, br_pend_o=0, then 0x184.
- Wrap: pc_o=0xFFFF_FFFC, no control inputs → pc_o=0x0000_0000.
- Mid-operation reset: pend=1, rst_n pulsed low asynchronously → pc_o=RESET_PC, ce_o=0 and br_pend_o=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mips_defs.sv
// Shared simplemips definitions: address width, instruction size, reset
// vector and the PC-generation state encoding reused by IF, ID and ctrl.
package mips_defs;

    localparam int          ADDR_W     = 32;
    localparam int          INST_BYTES = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter generation stage: selects the next fetch address from
// increment, ID branch, or flush redirect, and buffers branches seen during stalls.
module pc_reg
    import mips_defs::*;
#(
    parameter int                ADDR_W   = mips_defs::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_defs::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              br_pend_o
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            ce_q          <= 1'b0;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ce_q          <= ce_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ce_d          = ce_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        unique case (state_q)
            BOOT: begin
                // pc stays at RESET_PC so the first fetch is the reset vector
                state_d = RUN;
                ce_d    = 1'b1;
            end
            RUN: begin
                if (flush_i) begin
                    pc_d   = new_pc_i;
                    pend_d = 1'b0;
                end else if (stall_i) begin
                    if (branch_flag_i) begin
                        pend_d        = 1'b1;
                        pend_target_d = branch_target_i;
                    end
                end else if (branch_flag_i) begin
                    pc_d   = branch_target_i;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pc_d   = pend_target_q;
                    pend_d = 1'b0;
                end else begin
                    pc_d = pc_q + ADDR_W'(INST_BYTES);
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign pc_o      = pc_q;
    assign ce_o      = ce_q;
    assign br_pend_o = pend_q;

endmodule

// File: tb/tb_pc_reg.sv
// Directed plus random bench for pc_reg against a queue-based fetch-address model.
module tb_pc_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic        br_pend_o;

    int total = 0;
    int bad   = 0;

    // model: running flag, current address, and a one-deep queue of buffered branch targets
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] exp_q[$];

    pc_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .new_pc_i       (new_pc_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .pc_o           (pc_o),
        .ce_o           (ce_o),
        .br_pend_o      (br_pend_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = 32'h0000_0000;
        exp_q.delete();
    endtask

    task automatic model_edge();
        if (!m_run) begin
            m_run = 1'b1;
        end else if (flush_i) begin
            m_pc = new_pc_i;
            exp_q.delete();
        end else if (stall_i) begin
            if (branch_flag_i) begin
                exp_q.delete();
                exp_q.push_back(branch_target_i);
            end
        end else if (branch_flag_i) begin
            m_pc = branch_target_i;
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            m_pc = exp_q.pop_front();
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string tag);
        logic exp_pend;
        exp_pend = (exp_q.size() != 0);
        total++;
        assert (pc_o === m_pc) else begin
            bad++;
            $error("FAIL %s pc_o got=%h exp=%h", tag, pc_o, m_pc);
        end
        total++;
        assert (ce_o === m_run) else begin
            bad++;
            $error("FAIL %s ce_o got=%b exp=%b", tag, ce_o, m_run);
        end
        total++;
        assert (br_pend_o === exp_pend) else begin
            bad++;
            $error("FAIL %s br_pend_o got=%b exp=%b", tag, br_pend_o, exp_pend);
        end
    endtask

    task automatic check_pc(input string tag, input logic [31:0] want);
        total++;
        assert (pc_o === want) else begin
            bad++;
            $error("FAIL %s pc_o got=%h exp=%h", tag, pc_o, want);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic [31:0] npc,
                         input logic br, input logic [31:0] tgt);
        stall_i         = st;
        flush_i         = fl;
        new_pc_i        = npc;
        branch_flag_i   = br;
        branch_target_i = tgt;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset");
        rst_n = 1'b1;
        #1;
        check("boot_hold");

        // reset release: boot edge, then 0, 4, 8
        step("boot_edge");
        check_pc("first_fetch", 32'h0);
        idle("seq4");
        idle("seq8");
        check_pc("seq8_abs", 32'h8);

        // branch while pc=8
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
        step("branch");
        check_pc("branch_abs", 32'h100);
        idle("branch_inc");
        check_pc("branch_inc_abs", 32'h104);

        // stall 3 cycles with branch captured in the first
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
        step("stall1");
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("stall2");
        step("stall3");
        check_pc("stall_hold_abs", 32'h104);
        idle("release");
        check_pc("release_abs", 32'h200);

        // flush beats stall and branch together
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0240);
        step("pend_before_flush");
        drive(1'b1, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_0300);
        step("flush_prio");
        check_pc("flush_abs", 32'h180);
        idle("flush_inc");

        // new unstalled branch overrides an existing pend
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0400);
        step("pend_again");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0500);
        step("branch_over_pend");
        idle("after_override");

        // wrap around the top of the address space
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step("to_top");
        idle("wrap");
        check_pc("wrap_abs", 32'h0);

        // mid-operation async reset with a pending branch
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0600);
        step("pend_before_reset");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset");
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("reset_held");
        rst_n = 1'b1;
        step("reboot");
        idle("reboot_inc");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            logic [31:0] npc;
            tgt = $urandom();
            npc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom();
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, npc,
                  $urandom_range(0, 3) == 0, tgt);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
